// File: rtl/axi4_master_if.sv
// axi4_master_if: AXI4 read/write channel bundle between the burst initiator
// (master modport) and a memory-mapped slave (slave modport).
//   AW: AWADDR/AWLEN/AWSIZE/AWVALID -> , <- AWREADY
//   W : WDATA/WLAST/WVALID -> , <- WREADY
//   B : <- BRESP/BVALID , BREADY ->
//   AR: ARADDR/ARLEN/ARSIZE/ARVALID -> , <- ARREADY
//   R : <- RDATA/RRESP/RLAST/RVALID , RREADY ->
interface axi4_master_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 10
);
   logic [ADDR_WIDTH-1:0] AWADDR;
   logic [7:0]            AWLEN;
   logic [2:0]            AWSIZE;
   logic                  AWVALID;
   logic                  AWREADY;

   logic [DATA_WIDTH-1:0] WDATA;
   logic                  WLAST;
   logic                  WVALID;
   logic                  WREADY;

   logic [1:0]            BRESP;
   logic                  BVALID;
   logic                  BREADY;

   logic [ADDR_WIDTH-1:0] ARADDR;
   logic [7:0]            ARLEN;
   logic [2:0]            ARSIZE;
   logic                  ARVALID;
   logic                  ARREADY;

   logic [DATA_WIDTH-1:0] RDATA;
   logic [1:0]            RRESP;
   logic                  RLAST;
   logic                  RVALID;
   logic                  RREADY;

   modport master (
      output AWADDR, AWLEN, AWSIZE, AWVALID, input AWREADY,
      output WDATA, WLAST, WVALID, input WREADY,
      input BRESP, BVALID, output BREADY,
      output ARADDR, ARLEN, ARSIZE, ARVALID, input ARREADY,
      input RDATA, RRESP, RLAST, RVALID, output RREADY
   );

   modport slave (
      input AWADDR, AWLEN, AWSIZE, AWVALID, output AWREADY,
      input WDATA, WLAST, WVALID, output WREADY,
      output BRESP, BVALID, input BREADY,
      input ARADDR, ARLEN, ARSIZE, ARVALID, output ARREADY,
      output RDATA, RRESP, RLAST, RVALID, input RREADY
   );
endinterface

// File: rtl/axi4_master.sv
// axi4_master: command-driven single-burst AXI4 initiator.
// Accepts one read or write burst command, runs the AW/W/B or AR/R handshakes,
// passes write beats from the local feed and read beats to the local sink with
// no added latency, then pulses done with the response code.
// Ports:
//   ACLK, ARESETn (synchronous, active-low)
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_len : burst command
//   wr_data/wr_valid/wr_ready                      : local write beat feed
//   rd_data/rd_valid/rd_last/rd_ready              : local read beat sink
//   done/done_resp/done_err                        : completion report
//   axi                                            : AXI4 master channels
// Optional feature: define AXI4_MASTER_RANGE_CHECK_EN to reject misaligned or
// out-of-range commands with done_err/SLVERR instead of issuing them.
module axi4_master #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                  ACLK,
   input  logic                  ARESETn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [7:0]            cmd_len,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  rd_last,
   input  logic                  rd_ready,
   output logic                  done,
   output logic [1:0]            done_resp,
   output logic                  done_err,
   axi4_master_if.master         axi
);

   localparam int unsigned BEAT_BYTES = DATA_WIDTH / 8;
   localparam logic [2:0]  AX_SIZE    = 3'($clog2(BEAT_BYTES));

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_ADDR = 3'd1,
      WR_DATA = 3'd2,
      WR_RESP = 3'd3,
      RD_ADDR = 3'd4,
      RD_DATA = 3'd5
   } state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [7:0]            len_q;
   logic [7:0]            beat_cnt;
   logic [1:0]            resp_acc;

   logic                  cmd_hs_c;
   logic                  cmd_bad_c;
   logic                  last_c;
   logic                  w_hs_c;
   logic                  b_hs_c;
   logic                  r_hs_c;
   logic                  r_end_c;
   logic [1:0]            rresp_max_c;

   // Handshake and beat-tracking terms shared by the FSM and datapath
   assign cmd_hs_c    = cmd_valid && cmd_ready;
   assign last_c      = (beat_cnt == len_q);
   assign w_hs_c      = (state == WR_DATA) && wr_valid && axi.WREADY;
   assign b_hs_c      = (state == WR_RESP) && axi.BVALID;
   assign r_hs_c      = (state == RD_DATA) && axi.RVALID && rd_ready;
   // A read burst ends on whichever comes first: slave RLAST or our own count
   assign r_end_c     = r_hs_c && (axi.RLAST || last_c);
   assign rresp_max_c = (axi.RRESP > resp_acc) ? axi.RRESP : resp_acc;

`ifdef AXI4_MASTER_RANGE_CHECK_EN
   // Extra headroom so the end address cannot wrap while being compared
   localparam int unsigned EXT_W = ADDR_WIDTH + 12;

   logic [EXT_W-1:0] cmd_end_c;
   logic             cmd_misaligned_c;

   assign cmd_misaligned_c = (cmd_addr & ADDR_WIDTH'(BEAT_BYTES - 1)) != '0;
   assign cmd_end_c        = EXT_W'(cmd_addr)
                           + ((EXT_W'(cmd_len) + EXT_W'(1)) * EXT_W'(BEAT_BYTES));
   assign cmd_bad_c        = cmd_misaligned_c
                           || (cmd_end_c > (EXT_W'(1) << ADDR_WIDTH));
`else
   assign cmd_bad_c = 1'b0;
`endif

   // State register
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (cmd_hs_c && !cmd_bad_c) begin
               state_nxt = cmd_write ? WR_ADDR : RD_ADDR;
            end
         end
         WR_ADDR: if (axi.AWREADY) state_nxt = WR_DATA;
         WR_DATA: if (w_hs_c && last_c) state_nxt = WR_RESP;
         WR_RESP: if (axi.BVALID) state_nxt = IDLE;
         RD_ADDR: if (axi.ARREADY) state_nxt = RD_DATA;
         RD_DATA: if (r_end_c) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Channel outputs; address/len come straight from the captured command so
   // they stay stable for as long as VALID is held
   always_comb begin
      cmd_ready   = 1'b0;
      wr_ready    = 1'b0;
      rd_valid    = 1'b0;
      rd_data     = axi.RDATA;
      rd_last     = axi.RLAST;
      axi.AWADDR  = addr_q;
      axi.AWLEN   = len_q;
      axi.AWSIZE  = AX_SIZE;
      axi.AWVALID = 1'b0;
      axi.WDATA   = wr_data;
      axi.WLAST   = 1'b0;
      axi.WVALID  = 1'b0;
      axi.BREADY  = 1'b0;
      axi.ARADDR  = addr_q;
      axi.ARLEN   = len_q;
      axi.ARSIZE  = AX_SIZE;
      axi.ARVALID = 1'b0;
      axi.RREADY  = 1'b0;
      case (state)
         // Held off while reset is asserted so no command is offered early
         IDLE:    cmd_ready = ARESETn;
         WR_ADDR: axi.AWVALID = 1'b1;
         WR_DATA: begin
            axi.WVALID = wr_valid;
            axi.WLAST  = last_c;
            wr_ready   = axi.WREADY;
         end
         WR_RESP: axi.BREADY = 1'b1;
         RD_ADDR: axi.ARVALID = 1'b1;
         RD_DATA: begin
            axi.RREADY = rd_ready;
            rd_valid   = axi.RVALID;
         end
         default: ;
      endcase
   end

   // Command capture, beat counter, response accumulation and completion
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         addr_q    <= '0;
         len_q     <= '0;
         beat_cnt  <= '0;
         resp_acc  <= '0;
         done      <= 1'b0;
         done_resp <= 2'b00;
         done_err  <= 1'b0;
      end else begin
         done     <= 1'b0;
         done_err <= 1'b0;
         if (cmd_hs_c) begin
            addr_q   <= cmd_addr;
            len_q    <= cmd_len;
            beat_cnt <= '0;
            resp_acc <= 2'b00;
            // Rejected commands complete immediately with SLVERR
            if (cmd_bad_c) begin
               done      <= 1'b1;
               done_err  <= 1'b1;
               done_resp <= 2'b10;
            end
         end
         if (w_hs_c) begin
            beat_cnt <= beat_cnt + 8'd1;
         end
         if (b_hs_c) begin
            done      <= 1'b1;
            done_resp <= axi.BRESP;
         end
         if (r_hs_c) begin
            beat_cnt <= beat_cnt + 8'd1;
            resp_acc <= rresp_max_c;
         end
         if (r_end_c) begin
            done      <= 1'b1;
            done_resp <= rresp_max_c;
            // Slave RLAST and our expected length must agree on the final beat
            done_err  <= axi.RLAST != last_c;
         end
      end
   end

endmodule

// File: tb/tb_axi4_master.sv
// tb_axi4_master: directed self-checking bench for axi4_master. The bench
// plays the AXI slave with a small word memory; expected beats are queued when
// stimulus is issued and popped when the DUT moves a beat.
module tb_axi4_master;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 10;

   logic          ACLK;
   logic          ARESETn;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [7:0]    cmd_len;
   logic [DW-1:0] wr_data;
   logic          wr_valid;
   logic          wr_ready;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          rd_last;
   logic          rd_ready;
   logic          done;
   logic [1:0]    done_resp;
   logic          done_err;

   axi4_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) axi ();

   axi4_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .ACLK      (ACLK),
      .ARESETn   (ARESETn),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .wr_data   (wr_data),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .rd_last   (rd_last),
      .rd_ready  (rd_ready),
      .done      (done),
      .done_resp (done_resp),
      .done_err  (done_err),
      .axi       (axi)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   int            n_cmp = 0;
   int            n_err = 0;
   logic [31:0]   exp_q[$];
   logic [31:0]   mem [0:255];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   // Write burst; aw_stall = cycles AWREADY stays low, rst_beat >= 0 pulses reset on that beat
   task automatic run_write(input logic [AW-1:0] addr, input logic [7:0] len,
                            input logic [31:0] base, input int aw_stall,
                            input int rst_beat, input logic [1:0] bresp);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addr; cmd_len = len;
      #1;
      check("wr_cmd_ready", 32'(cmd_ready), 32'd1);
      tick();
      cmd_valid = 1'b0;
      wr_valid  = 1'b1;
      wr_data   = base;
      for (int s = 0; s <= aw_stall; s++) begin
         axi.AWREADY = (s == aw_stall);
         #1;
         check("awvalid", 32'(axi.AWVALID), 32'd1);
         check("awaddr", 32'(axi.AWADDR), 32'(addr));
         check("awlen", 32'(axi.AWLEN), 32'(len));
         check("awsize", 32'(axi.AWSIZE), 32'd2);
         check("wvalid_before_aw", 32'(axi.WVALID), 32'd0);
         tick();
      end
      axi.AWREADY = 1'b0;
      axi.WREADY  = 1'b1;
      for (int i = 0; i <= int'(len); i++) begin
         wr_data  = base + 32'(i);
         wr_valid = 1'b1;
         if (i == rst_beat) begin
            ARESETn = 1'b0;
            tick();
            ARESETn = 1'b1; wr_valid = 1'b0; axi.WREADY = 1'b0;
            #1;
            check("rst_awvalid", 32'(axi.AWVALID), 32'd0);
            check("rst_wvalid", 32'(axi.WVALID), 32'd0);
            check("rst_arvalid", 32'(axi.ARVALID), 32'd0);
            check("rst_bready", 32'(axi.BREADY), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
            tick();
            check("rst_no_done_later", 32'(done), 32'd0);
            return;
         end
         exp_q.push_back(base + 32'(i));
         #1;
         check("wvalid", 32'(axi.WVALID), 32'd1);
         check("wr_ready", 32'(wr_ready), 32'd1);
         check("wlast", 32'(axi.WLAST), 32'(i == int'(len)));
         if (axi.WVALID && axi.WREADY) begin
            check("wdata", axi.WDATA, exp_q.pop_front());
            mem[8'(int'(addr >> 2) + i)] = axi.WDATA;
         end
         tick();
      end
      wr_valid = 1'b0; axi.WREADY = 1'b0;
      #1;
      check("bready", 32'(axi.BREADY), 32'd1);
      check("wvalid_after_last", 32'(axi.WVALID), 32'd0);
      axi.BVALID = 1'b1; axi.BRESP = bresp;
      tick();
      axi.BVALID = 1'b0; axi.BRESP = 2'b00;
      #1;
      check("wr_done", 32'(done), 32'd1);
      check("wr_done_resp", 32'(done_resp), 32'(bresp));
      check("wr_done_err", 32'(done_err), 32'd0);
      check("wr_done_cmd_ready", 32'(cmd_ready), 32'd1);
      tick();
      check("wr_done_pulse", 32'(done), 32'd0);
   endtask

   // Read burst; err_beat gets RRESP=SLVERR, last_beat forces an early RLAST
   task automatic run_read(input logic [AW-1:0] addr, input logic [7:0] len,
                           input logic [31:0] base, input int n_exp, input bit toggle,
                           input int err_beat, input int last_beat,
                           input logic [1:0] exp_resp, input logic exp_err);
      int  b;
      bit  fin;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr; cmd_len = len;
      #1;
      check("rd_cmd_ready", 32'(cmd_ready), 32'd1);
      tick();
      cmd_valid = 1'b0;
      #1;
      check("arvalid", 32'(axi.ARVALID), 32'd1);
      check("araddr", 32'(axi.ARADDR), 32'(addr));
      check("arlen", 32'(axi.ARLEN), 32'(len));
      check("arsize", 32'(axi.ARSIZE), 32'd2);
      check("rd_awvalid", 32'(axi.AWVALID), 32'd0);
      axi.ARREADY = 1'b1;
      tick();
      axi.ARREADY = 1'b0;
      for (int k = 0; k < n_exp; k++) exp_q.push_back(base + 32'(k));
      b   = 0;
      fin = 1'b0;
      for (int c = 0; c < 64 && !fin; c++) begin
         rd_ready    = toggle ? (c % 2 == 1) : 1'b1;
         axi.RVALID  = 1'b1;
         axi.RDATA   = mem[8'(int'(addr >> 2) + b)];
         axi.RRESP   = (b == err_beat) ? 2'b10 : 2'b00;
         axi.RLAST   = (b == int'(len)) || (b == last_beat);
         #1;
         check("rready", 32'(axi.RREADY), 32'(rd_ready));
         check("rd_valid", 32'(rd_valid), 32'd1);
         check("rd_last", 32'(rd_last), 32'(axi.RLAST));
         if (rd_ready) begin
            if (exp_q.size() > 0) check("rd_data", rd_data, exp_q.pop_front());
            else check("rd_beat_count", 32'(b), 32'(n_exp));
            fin = axi.RLAST || (b == int'(len));
            b++;
         end
         tick();
      end
      axi.RVALID = 1'b0; axi.RLAST = 1'b0; axi.RRESP = 2'b00; rd_ready = 1'b0;
      check("rd_finished_in_budget", 32'(fin), 32'd1);
      #1;
      check("rd_done", 32'(done), 32'd1);
      check("rd_done_resp", 32'(done_resp), 32'(exp_resp));
      check("rd_done_err", 32'(done_err), 32'(exp_err));
      check("rd_done_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rd_beats", 32'(b), 32'(n_exp));
      check("rd_queue_empty", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      tick();
      check("rd_done_pulse", 32'(done), 32'd0);
   endtask

`ifdef AXI4_MASTER_RANGE_CHECK_EN
   task automatic range_bad(input logic [AW-1:0] addr, input logic [7:0] len, input logic wr);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
      #1;
      check("rc_cmd_ready", 32'(cmd_ready), 32'd1);
      tick();
      cmd_valid = 1'b0;
      #1;
      check("rc_done", 32'(done), 32'd1);
      check("rc_done_err", 32'(done_err), 32'd1);
      check("rc_done_resp", 32'(done_resp), 32'd2);
      check("rc_awvalid", 32'(axi.AWVALID), 32'd0);
      check("rc_arvalid", 32'(axi.ARVALID), 32'd0);
      tick();
      check("rc_done_pulse", 32'(done), 32'd0);
      check("rc_awvalid_later", 32'(axi.AWVALID), 32'd0);
      check("rc_arvalid_later", 32'(axi.ARVALID), 32'd0);
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'd0;
      ARESETn = 1'b0;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
      wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
      axi.AWREADY = 1'b0; axi.WREADY = 1'b0; axi.BRESP = 2'b00; axi.BVALID = 1'b0;
      axi.ARREADY = 1'b0; axi.RDATA = '0; axi.RRESP = 2'b00; axi.RLAST = 1'b0;
      axi.RVALID = 1'b0;

      // Reset state
      tick();
      tick();
      check("reset_cmd_ready", 32'(cmd_ready), 32'd0);
      check("reset_awvalid", 32'(axi.AWVALID), 32'd0);
      check("reset_wvalid", 32'(axi.WVALID), 32'd0);
      check("reset_arvalid", 32'(axi.ARVALID), 32'd0);
      check("reset_bready", 32'(axi.BREADY), 32'd0);
      check("reset_rready", 32'(axi.RREADY), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_done_resp", 32'(done_resp), 32'd0);
      check("reset_done_err", 32'(done_err), 32'd0);
      ARESETn = 1'b1;
      #1;
      check("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);
      tick();

      // Write 0xA0..0xA3 then read back with a toggling sink
      run_write(10'h010, 8'd3, 32'hA0, 0, -1, 2'b00);
      run_read(10'h010, 8'd3, 32'hA0, 4, 1'b1, -1, -1, 2'b00, 1'b0);

      // AWREADY stalled for 5 cycles, EXOKAY write response
      run_write(10'h040, 8'd1, 32'hB0, 5, -1, 2'b01);

      // SLVERR on beat 1 of 2, then early RLAST on beat 0 of 2
      run_read(10'h010, 8'd1, 32'hA0, 2, 1'b0, 1, -1, 2'b10, 1'b0);
      run_read(10'h010, 8'd1, 32'hA0, 1, 1'b0, -1, 0, 2'b00, 1'b1);

      // Reset during write beat 2, then a clean write and read-back
      run_write(10'h080, 8'd3, 32'hC0, 0, 2, 2'b00);
      run_write(10'h080, 8'd3, 32'hD0, 0, -1, 2'b00);
      run_read(10'h080, 8'd3, 32'hD0, 4, 1'b0, -1, -1, 2'b00, 1'b0);

      // Single-beat write (len 0)
      run_write(10'h100, 8'd0, 32'hE0, 1, -1, 2'b00);

`ifdef AXI4_MASTER_RANGE_CHECK_EN
      range_bad(10'h3F8, 8'd3, 1'b1);
      range_bad(10'h002, 8'd0, 1'b0);
`else
      // Without the check a misaligned command is issued unchanged
      run_read(10'h002, 8'd0, mem[0], 1, 1'b0, -1, -1, 2'b00, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/axi4_master.md
# axi4_master

Command-driven AXI4 burst initiator: the requesting end of the read/write channels served by the team's AXI4 memory-mapped slave. It accepts a single-burst command (read or write, start address, length) from a local requester. It drives the AW/W/B or AR/R handshakes, streams write data in from a local feed and read data out to a local sink, then reports completion with the response code. Intended as the stimulus/traffic engine in front of the slave-plus-memory subsystem.

## Interface
- DATA_WIDTH, 32, data bus width; beat size is DATA_WIDTH/8 bytes
- ADDR_WIDTH, 10, byte-address width of AWADDR/ARADDR/cmd_addr
- ACLK  input  1  clock; all logic rising-edge
- ARESETn  input  1  reset; synchronous, active-low
- cmd_valid  input  1  command offered
- cmd_ready  output  1  high only in IDLE
- cmd_write  input  1  1 = write burst, 0 = read burst
- cmd_addr  input  ADDR_WIDTH  start byte address
- cmd_len  input  8  beats minus one (AxLEN encoding)
- wr_data  input  DATA_WIDTH  write beat from requester
- wr_valid  input  1  write beat available
- wr_ready  output  1  write beat consumed (= WREADY while in WR_DATA)
- rd_data  output  DATA_WIDTH  read beat (= RDATA)
- rd_valid  output  1  read beat valid (= RVALID while in RD_DATA)
- rd_last  output  1  last read beat (= RLAST)
- rd_ready  input  1  sink accepts beat (drives RREADY in RD_DATA)
- done  output  1  one-cycle completion pulse
- done_resp  output  2  BRESP, or worst RRESP seen in the burst
- done_err  output  1  with done: RLAST mismatch or rejected command
- AWADDR/AWLEN/AWSIZE/AWVALID outputs, AWREADY input: write address channel
- WDATA/WLAST/WVALID outputs, WREADY input: write data channel
- BRESP/BVALID inputs, BREADY output: write response channel
- ARADDR/ARLEN/ARSIZE/ARVALID outputs, ARREADY input: read address channel
- RDATA/RRESP/RLAST/RVALID inputs, RREADY output: read data channel

## Operation
- States: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA.
- IDLE: cmd_ready=1; on cmd_valid capture addr/len/write into registers, go WR_ADDR or RD_ADDR.
- WR_ADDR: AWVALID=1, AWADDR/AWLEN from captured registers, AWSIZE=log2(DATA_WIDTH/8) (3'b010 at default); on AWREADY go WR_DATA.
- WR_DATA: WVALID=wr_valid, WDATA=wr_data, wr_ready=WREADY; 8-bit beat counter from 0; WLAST=(count==len); on WVALID&&WREADY&&WLAST go WR_RESP.
- WR_RESP: BREADY=1; on BVALID register done=1, done_resp=BRESP, go IDLE.
- RD_ADDR: ARVALID=1, ARSIZE as AWSIZE; on ARREADY go RD_DATA.
- RD_DATA: RREADY=rd_ready; per handshake increment counter, done_resp accumulates max(RRESP). Terminate on handshake with RLAST or with count==len, whichever first. done_err=1 if RLAST and count==len disagree on that beat.
- Only one burst outstanding; no AW/W overlap, no write data before AW handshake.
- len=0: single beat, WLAST high on first beat.

## Timing
- Reset: all VALID/READY outputs 0, cmd_ready 0 during reset then 1, done/done_err 0, done_resp 2'b00, counter 0, state IDLE.
- Command accepted edge N -> AWVALID/ARVALID high from cycle N+1.
- VALID held with stable address/len until READY sampled high; never dropped early.
- done pulses the cycle after the B handshake / final R handshake; cmd_ready high that same cycle, so back-to-back commands lose one cycle.
- Write/read data paths combinational passthrough, zero added latency; throughput one beat/cycle.
- ARESETn low mid-burst: next edge returns to IDLE, VALIDs drop; no done pulse.

## Configuration
- AXI4_MASTER_RANGE_CHECK_EN defined: in IDLE a command with cmd_addr not beat-aligned, or cmd_addr+(cmd_len+1)*beat_bytes > 2**ADDR_WIDTH, is accepted (cmd_ready handshake) but not issued. The next cycle produces done=1, done_err=1, done_resp=2'b10.
- Undefined: no check; all commands issued as given.

## Test plan
- Write addr 0x010, len 3, data 0xA0..0xA3, slave ready always -> AW once, 4 W beats, WLAST on beat 3, done with done_resp 2'b00 one cycle after B.
- Read back addr 0x010, len 3, rd_ready toggling every cycle -> rd_data 0xA0..0xA3 in order, rd_last on 4th beat, done, done_err=0.
- AWREADY held low 5 cycles -> AWVALID and AWADDR stable throughout, no WVALID before handshake.
- Read with slave RRESP 2'b10 on beat 1 of 2 -> done_resp 2'b10; slave RLAST on beat 0 of len 1 -> done_err=1.
- ARESETn low for 1 cycle during WR_DATA beat 2 -> all VALIDs 0, IDLE, no done; next command runs cleanly.
- With AXI4_MASTER_RANGE_CHECK_EN: addr 0x3F8, len 3 -> no AWVALID, done=1, done_err=1, done_resp 2'b10; addr 0x002 likewise.
